// File: rtl/skolem_ult_not_checker.sv
// Bit-serial witness checker for the bvult/bvnot Skolem family.
// Accepts one (x, y) pair per transaction and checks x <u ~y MSB first over
// W cycles. It reports whether a witness exists (~y != 0), whether x
// satisfies the constraint, and whether the Skolem function failed.
// It also keeps saturating totals of checks and failures.
// Optional feature: define SKOLEM_CHECKER_CEX_CAPTURE_EN to latch the first
// failing (x, y) pair into cex_x/cex_y. When undefined, the cex outputs are 0.
module skolem_ult_not_checker #(
    parameter int W  = 4,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_x,
    input  logic [W-1:0]  in_y,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_sat,
    output logic          out_exists,
    output logic          out_fail,
    output logic [CW-1:0] checks_total,
    output logic [CW-1:0] fails_total,
    output logic          cex_valid,
    output logic [W-1:0]  cex_x,
    output logic [W-1:0]  cex_y
);

    localparam int BW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t         state;
    logic [W-1:0]   sx;
    logic [W-1:0]   sny;
    logic [BW-1:0]  bit_cnt;
    logic           lt;
    logic           gt;
    logic           nz;
    logic           bit_a;
    logic           bit_b;
    logic           accept;
    logic           handshake;

    assign bit_a     = sx[W-1];
    assign bit_b     = sny[W-1];
    assign accept    = in_valid & in_ready;
    assign handshake = out_valid & out_ready;

    // Saturating increment: a counter parks at all-ones instead of wrapping.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        logic [CW-1:0] one;
        one = {{(CW-1){1'b0}}, 1'b1};
        return (v == {CW{1'b1}}) ? v : v + one;
    endfunction

    // Control FSM: accept a pair, shift W bits MSB first, then hold the result.
    // The comparison always runs all W cycles, so the latency is fixed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_sat    <= 1'b0;
            out_exists <= 1'b0;
            out_fail   <= 1'b0;
            sx         <= '0;
            sny        <= '0;
            bit_cnt    <= '0;
            lt         <= 1'b0;
            gt         <= 1'b0;
            nz         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sx       <= in_x;
                        sny      <= ~in_y;
                        bit_cnt  <= BW'(W - 1);
                        lt       <= 1'b0;
                        gt       <= 1'b0;
                        nz       <= 1'b0;
                        in_ready <= 1'b0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    // The first differing bit decides the order. Later bits
                    // must not change it.
                    if (!lt && !gt) begin
                        if (!bit_a && bit_b) begin
                            lt <= 1'b1;
                        end else if (bit_a && !bit_b) begin
                            gt <= 1'b1;
                        end
                    end
                    nz  <= nz | bit_b;
                    sx  <= {sx[W-2:0], 1'b0};
                    sny <= {sny[W-2:0], 1'b0};
                    if (bit_cnt == '0) begin
                        state <= DONE;
                    end else begin
                        bit_cnt <= bit_cnt - BW'(1);
                    end
                end
                DONE: begin
                    // First DONE cycle registers the result. It then stays
                    // stable until the consumer takes it.
                    if (!out_valid) begin
                        out_valid  <= 1'b1;
                        out_sat    <= lt;
                        out_exists <= nz;
                        out_fail   <= nz & ~lt;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

    // Statistics: count every completed result handshake, and the failing ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            checks_total <= '0;
            fails_total  <= '0;
        end else if (handshake) begin
            checks_total <= sat_inc(checks_total);
            if (out_fail) begin
                fails_total <= sat_inc(fails_total);
            end
        end
    end

`ifdef SKOLEM_CHECKER_CEX_CAPTURE_EN
    logic [W-1:0] orig_x;
    logic [W-1:0] orig_y;

    // Keep the untouched operands, because the shift registers are consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            orig_x <= '0;
            orig_y <= '0;
        end else if (accept) begin
            orig_x <= in_x;
            orig_y <= in_y;
        end
    end

    // Latch the first failing pair only. Only reset clears the capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cex_valid <= 1'b0;
            cex_x     <= '0;
            cex_y     <= '0;
        end else if (handshake && out_fail && !cex_valid) begin
            cex_valid <= 1'b1;
            cex_x     <= orig_x;
            cex_y     <= orig_y;
        end
    end
`else
    assign cex_valid = 1'b0;
    assign cex_x     = '0;
    assign cex_y     = '0;
`endif

endmodule

// File: tb/tb_skolem_ult_not_checker.sv
// Directed testbench for skolem_ult_not_checker (W=4). A second instance
// with CW=2 exercises counter saturation.
module tb_skolem_ult_not_checker;

    localparam int W = 4;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [W-1:0] in_x;
    logic [W-1:0] in_y;
    logic        out_valid;
    logic        out_ready;
    logic        out_sat;
    logic        out_exists;
    logic        out_fail;
    logic [15:0] checks_total;
    logic [15:0] fails_total;
    logic        cex_valid;
    logic [W-1:0] cex_x;
    logic [W-1:0] cex_y;

    logic        s_in_valid;
    logic        s_in_ready;
    logic [W-1:0] s_in_x;
    logic [W-1:0] s_in_y;
    logic        s_out_valid;
    logic        s_out_ready;
    logic        s_out_sat;
    logic        s_out_exists;
    logic        s_out_fail;
    logic [1:0]  s_checks_total;
    logic [1:0]  s_fails_total;
    logic        s_cex_valid;
    logic [W-1:0] s_cex_x;
    logic [W-1:0] s_cex_y;

    int checks;
    int errors;

    skolem_ult_not_checker #(.W(W), .CW(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sat(out_sat), .out_exists(out_exists), .out_fail(out_fail),
        .checks_total(checks_total), .fails_total(fails_total),
        .cex_valid(cex_valid), .cex_x(cex_x), .cex_y(cex_y)
    );

    skolem_ult_not_checker #(.W(W), .CW(2)) dut_sat (
        .clk(clk), .rst(rst),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_x(s_in_x), .in_y(s_in_y),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_sat(s_out_sat), .out_exists(s_out_exists), .out_fail(s_out_fail),
        .checks_total(s_checks_total), .fails_total(s_fails_total),
        .cex_valid(s_cex_valid), .cex_x(s_cex_x), .cex_y(s_cex_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Offer a pair, then wait for the result and check its latency.
    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check("in_ready_idle", in_ready, 1);
        in_x = x;
        in_y = y;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("in_ready_busy", in_ready, 0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check("latency", n, W + 1);
    endtask

    // Full transaction with out_ready held high, checking results and counters.
    task automatic run_pair(input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic e_sat, input logic e_exists, input logic e_fail,
                            input int e_checks, input int e_fails);
        send(x, y);
        check("out_sat", out_sat, e_sat);
        check("out_exists", out_exists, e_exists);
        check("out_fail", out_fail, e_fail);
        @(posedge clk); #1;
        check("out_valid_after_hs", out_valid, 0);
        check("checks_total", checks_total, e_checks);
        check("fails_total", fails_total, e_fails);
    endtask

    task automatic check_cex(input logic e_valid, input logic [W-1:0] e_x, input logic [W-1:0] e_y);
`ifdef SKOLEM_CHECKER_CEX_CAPTURE_EN
        check("cex_valid", cex_valid, e_valid);
        check("cex_x", cex_x, e_x);
        check("cex_y", cex_y, e_y);
`else
        check("cex_valid_off", cex_valid, 0);
        check("cex_x_off", cex_x, 0);
        check("cex_y_off", cex_y, 0);
`endif
    endtask

    initial begin
        int n;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        in_x = '0;
        in_y = '0;
        out_ready = 1'b1;
        s_in_valid = 1'b0;
        s_in_x = '0;
        s_in_y = '0;
        s_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sat", out_sat, 0);
        check("rst_out_exists", out_exists, 0);
        check("rst_out_fail", out_fail, 0);
        check("rst_checks", checks_total, 0);
        check("rst_fails", fails_total, 0);
        check_cex(1'b0, 4'd0, 4'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic satisfied case: 3 < ~8 = 7.
        run_pair(4'd3, 4'd8, 1'b1, 1'b1, 1'b0, 1, 0);
        check_cex(1'b0, 4'd0, 4'd0);
        // Equality case 7 == ~8: not satisfied, so the Skolem function failed.
        run_pair(4'd7, 4'd8, 1'b0, 1'b1, 1'b1, 2, 1);
        check_cex(1'b1, 4'd7, 4'd8);
        // Later failure (9 == ~6) does not overwrite the capture.
        run_pair(4'd9, 4'd6, 1'b0, 1'b1, 1'b1, 3, 2);
        check_cex(1'b1, 4'd7, 4'd8);
        // 0110 vs ~1010 = 0101: gt at bit 1 must not be flipped by bit 0.
        run_pair(4'd6, 4'd10, 1'b0, 1'b1, 1'b1, 4, 3);
        // 0101 vs ~1001 = 0110: lt is decided at bit 1.
        run_pair(4'd5, 4'd9, 1'b1, 1'b1, 1'b0, 5, 3);
        // ~15 = 0: no witness exists, so this is not a failure.
        run_pair(4'd0, 4'd15, 1'b0, 1'b0, 1'b0, 6, 3);

        // Backpressure: hold the result for 5 cycles while offering a new pair.
        out_ready = 1'b0;
        send(4'd2, 4'd1);
        check("hold_sat0", out_sat, 1);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_x = 4'd3;
            in_y = 4'd3;
            @(posedge clk); #1;
            check("hold_valid", out_valid, 1);
            check("hold_sat", out_sat, 1);
            check("hold_fail", out_fail, 0);
            check("hold_in_ready", in_ready, 0);
            check("hold_checks", checks_total, 6);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("release_valid", out_valid, 0);
        check("release_checks", checks_total, 7);
        check("release_in_ready", in_ready, 1);
        @(posedge clk); #1;
        check("release_checks_once", checks_total, 7);
        check("release_valid_idle", out_valid, 0);

        // Reset asserted two cycles into SHIFT: the transaction is discarded.
        in_x = 4'd8;
        in_y = 4'd0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("midrst_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_checks", checks_total, 0);
        check("midrst_fails", fails_total, 0);
        check_cex(1'b0, 4'd0, 4'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid) n++;
        end
        check("midrst_no_result", n, 0);
        // ~0 = 15: 1 < 15.
        run_pair(4'd1, 4'd0, 1'b1, 1'b1, 1'b0, 1, 0);

        // CW=2 instance: 5 back-to-back failures saturate both counters at 3.
        for (int k = 0; k < 5; k++) begin
            n = 0;
            while (!s_in_ready && n < 50) begin
                @(posedge clk); #1; n++;
            end
            s_in_x = 4'd7;
            s_in_y = 4'd8;
            s_in_valid = 1'b1;
            @(posedge clk); #1;
            s_in_valid = 1'b0;
            n = 0;
            while (!s_out_valid && n < 20) begin
                @(posedge clk); #1; n++;
            end
            check("sat_fail_flag", s_out_fail, 1);
            @(posedge clk); #1;
            check("sat_checks", s_checks_total, (k < 3) ? k + 1 : 3);
            check("sat_fails", s_fails_total, (k < 3) ? k + 1 : 3);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
